// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: fetch-entry layout and defaults.
package imem_responder_pkg;

    localparam int          MAX_LATENCY      = 4;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam int          PC_W             = 32;
    localparam int          INSTR_W          = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               misaligned;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake between the IF stage (master) and the instruction memory (slave).
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_pc;
    logic [31:0] rsp_instruction;
    logic        rsp_misaligned;

    modport master (
        output req_valid, req_pc, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_pc, rsp_instruction, rsp_misaligned
    );

    modport slave (
        input  req_valid, req_pc, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_pc, rsp_instruction, rsp_misaligned
    );
endinterface

// File: rtl/imem_resp_fifo.sv
// Response buffer: small synchronous FIFO of fetch entries; clear_i empties it but keeps a same-cycle write.
module imem_resp_fifo
    import imem_responder_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         wen_i,
    input  fetch_entry_t wdata_i,
    input  logic         ren_i,
    output fetch_entry_t rdata_o,
    output logic         valid_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            rd_q  <= '0;
            wr_q  <= wen_i ? PTR_W'(1) : '0;
            cnt_q <= wen_i ? CNT_W'(1) : '0;
        end else begin
            if (wen_i) wr_q <= ptr_inc(wr_q);
            if (ren_i) rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CNT_W'(wen_i) - CNT_W'(ren_i);
        end
    end

    // Storage is not reset; outputs are qualified by valid_o at the top level.
    always_ff @(posedge clk_i) begin
        if (wen_i) mem_q[clr_i ? '0 : wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign valid_o = (cnt_q != '0);

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency, in-order fetch responses with credit flow control and flush.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    imem_responder_if.slave       fetch_if,
    input  logic                  load_en_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic [31:0]           load_data_i
);
    localparam int CAP   = LATENCY + 1;
    localparam int NSTG  = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam int CNT_W = $clog2(CAP + 1);

    logic [31:0]           mem_q [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  unused_pc_hi;
    logic                  accept;
    logic                  rsp_xfer;
    fetch_entry_t          new_entry;
    fetch_entry_t          fifo_wdata;
    fetch_entry_t          fifo_head;
    logic                  fifo_wen;
    logic                  fifo_valid;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rdy_en_q;

    assign accept       = fetch_if.req_valid & fetch_if.req_ready;
    assign rsp_xfer     = fifo_valid & fetch_if.rsp_ready;
    assign rd_idx       = fetch_if.req_pc[ADDR_WIDTH+1:2];
    assign unused_pc_hi = ^fetch_if.req_pc[31:ADDR_WIDTH+2];

    // Array read happens in the accept cycle; the write lands at the edge, so a same-cycle load reads old data.
    always_comb begin
        new_entry.pc         = fetch_if.req_pc;
        new_entry.misaligned = |fetch_if.req_pc[1:0];
        new_entry.instr      = new_entry.misaligned ? NOP_WORD : mem_q[rd_idx];
    end

    always_ff @(posedge clock_i) begin
        if (load_en_i) mem_q[load_addr_i] <= load_data_i;
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign fifo_wen   = accept;
            assign fifo_wdata = new_entry;
        end else begin : g_pipe
            logic [NSTG-1:0] vld_q;
            fetch_entry_t    ent_q [NSTG];

            // A fetch accepted in the flush cycle is the redirect target and survives.
            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= accept;
                    for (int i = 1; i < NSTG; i++) begin
                        vld_q[i] <= fetch_if.flush ? 1'b0 : vld_q[i-1];
                    end
                end
            end

            always_ff @(posedge clock_i) begin
                ent_q[0] <= new_entry;
                for (int i = 1; i < NSTG; i++) begin
                    ent_q[i] <= ent_q[i-1];
                end
            end

            assign fifo_wen   = vld_q[NSTG-1] & ~fetch_if.flush;
            assign fifo_wdata = ent_q[NSTG-1];
        end
    endgenerate

    imem_resp_fifo #(
        .DEPTH (CAP)
    ) u_resp_fifo (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .clr_i   (fetch_if.flush),
        .wen_i   (fifo_wen),
        .wdata_i (fifo_wdata),
        .ren_i   (rsp_xfer),
        .rdata_o (fifo_head),
        .valid_o (fifo_valid)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (fetch_if.flush) begin
            cnt_d = CNT_W'(accept);
        end else begin
            cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(rsp_xfer);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign fetch_if.req_ready       = rdy_en_q & (cnt_q < CNT_W'(CAP));
    assign fetch_if.rsp_valid       = fifo_valid;
    assign fetch_if.rsp_pc          = fifo_valid ? fifo_head.pc : '0;
    assign fetch_if.rsp_instruction = fifo_valid ? fifo_head.instr : '0;
    assign fetch_if.rsp_misaligned  = fifo_valid & fifo_head.misaligned;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with a scoreboard of expected fetch responses.
module tb_imem_responder;
    localparam int LATENCY = 2;
    localparam int AW      = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
        int          acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;

    imem_responder_if bus ();

    imem_responder #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LATENCY),
        .NOP_WORD   (32'h0)
    ) dut (
        .clock_i     (clk),
        .reset_i     (reset),
        .fetch_if    (bus),
        .load_en_i   (load_en),
        .load_addr_i (load_addr),
        .load_data_i (load_data)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    logic [31:0] mem_m [2**AW];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_pop    = 0;
    bit          chk_lat  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, update scoreboard and memory model, then move past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (reset) begin
            q.delete();
        end else begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
            end else if (bus.rsp_valid) begin
                e = q[0];
                chk("rsp_pc", 64'(bus.rsp_pc), 64'(e.pc));
                chk("rsp_instr", 64'(bus.rsp_instruction), 64'(e.instr));
                chk("rsp_mis", 64'(bus.rsp_misaligned), 64'(e.mis));
                if (bus.rsp_ready) begin
                    void'(q.pop_front());
                    n_pop++;
                    if (chk_lat) chk("latency", 64'(cyc - e.acc), 64'(LATENCY));
                end
            end
            if (bus.flush) q.delete();
            if (bus.req_valid && bus.req_ready) begin
                e.pc    = bus.req_pc;
                e.mis   = |bus.req_pc[1:0];
                e.instr = e.mis ? 32'h0 : mem_m[bus.req_pc[AW+1:2]];
                e.acc   = cyc;
                q.push_back(e);
            end
            if (load_en) mem_m[load_addr] = load_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while (q.size() > 0 && b < budget) begin
            cycle();
            b++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    task automatic fetch(input logic [31:0] pc);
        bus.req_valid = 1'b1;
        bus.req_pc    = pc;
        cycle();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int pops0;
        logic [31:0] pc;

        reset         = 1'b1;
        load_en       = 1'b0;
        load_addr     = '0;
        load_data     = '0;
        bus.req_valid = 1'b0;
        bus.req_pc    = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;
        cycle();
        cycle();
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_pc", 64'(bus.rsp_pc), 64'd0);
        chk("rst_rsp_instr", 64'(bus.rsp_instruction), 64'd0);
        chk("rst_rsp_mis", 64'(bus.rsp_misaligned), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);

        // Test 1: load word 5, fetch 0x14
        reset     = 1'b0;
        load_en   = 1'b1;
        load_addr = 8'd5;
        load_data = 32'h2008_0005;
        cycle();
        load_en = 1'b0;
        chk("ready_after_reset", 64'(bus.req_ready), 64'd1);
        chk_lat = 1'b1;
        fetch(32'h14);
        drain(10);

        for (int i = 0; i < 16; i++) begin
            if (i != 5) begin
                load_en   = 1'b1;
                load_addr = AW'(i);
                load_data = 32'hA000_0000 + 32'(i);
                cycle();
            end
        end
        load_en = 1'b0;

        // Test 2: back-to-back fetches
        for (int i = 0; i < 3; i++) begin
            chk("b2b_ready", 64'(bus.req_ready), 64'd1);
            bus.req_valid = 1'b1;
            bus.req_pc    = 32'(i * 4);
            cycle();
        end
        bus.req_valid = 1'b0;
        drain(10);

        // Test 3: backpressure fills the credits
        chk_lat       = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        pc            = 32'h10;
        acc           = 0;
        for (int i = 0; i < 6; i++) begin
            bus.req_pc = pc;
            if (bus.req_ready) begin
                acc++;
                pc += 32'd4;
            end
            cycle();
        end
        chk("bp_accepts", 64'(acc), 64'd3);
        chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        pops0 = n_pop;
        drain(10);
        chk("bp_pops", 64'(n_pop - pops0), 64'd3);
        chk("bp_ready_back", 64'(bus.req_ready), 64'd1);

        // Test 4: flush kills two in flight, keeps the redirect target
        bus.rsp_ready = 1'b0;
        fetch(32'h20);
        fetch(32'h24);
        bus.flush = 1'b1;
        fetch(32'h40);
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;
        chk("flush_valid_next", 64'(bus.rsp_valid), 64'd0);
        chk_lat = 1'b1;
        pops0   = n_pop;
        drain(10);
        chk("flush_pops", 64'(n_pop - pops0), 64'd1);

        // Response transferring in the flush cycle still completes
        fetch(32'h30);
        cycle();
        pops0     = n_pop;
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        chk("flush_xfer_pop", 64'(n_pop - pops0), 64'd1);
        for (int i = 0; i < 4; i++) cycle();
        chk("flush_credit_ready", 64'(bus.req_ready), 64'd1);

        // Test 5: misaligned fetch, and upper-PC aliasing
        fetch(32'h6);
        drain(10);
        fetch(32'h0000_0414);
        drain(10);

        // Test 6: read-first on a same-cycle load
        load_en       = 1'b1;
        load_addr     = 8'd3;
        load_data     = 32'hBBBB_0003;
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'hC;
        cycle();
        load_en       = 1'b0;
        bus.req_valid = 1'b0;
        drain(10);
        fetch(32'hC);
        drain(10);

        // Reset with two fetches in flight
        fetch(32'h0);
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'h4;
        cycle();
        bus.req_valid = 1'b0;
        cycle();
        chk("midrst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_ready", 64'(bus.req_ready), 64'd0);
        reset = 1'b0;
        cycle();
        chk("midrst_ready_after", 64'(bus.req_ready), 64'd1);
        for (int i = 0; i < 6; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
